ext_int_ctrl: RTL and testbench
===============================

# ext_int_ctrl

External-interrupt front end that generates the `int_exIO0` and `int_exIO1` request lines consumed by the interrupt controller. It synchronises the active-low pins INT0#/INT1#, performs level or falling-edge detection per the TCON mode bits, and holds IE0/IE1. It owns TCON[3:0] on the naive-memory SFR bus. Edge-mode flags are cleared by hardware when the controller acknowledges the matching vector.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchroniser depth (≥2)
- `FILTER_LEN`, 3, glitch-filter stable-sample count (used only with `EXINT_GLITCH_FILTER_EN`, ≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_sel`  in  1  bus select
- `mem_addr`  in  16  address; only [7:0] decoded
- `mem_we_n`  in  1  write strobe, active low
- `mem_rd_n`  in  1  read strobe, active low
- `mem_sfr_n`  in  1  SFR space select, active low
- `mem_wdata`  in  8  write data
- `mem_rdata`  out  8  read data
- `mem_ready_out`  out  1  constant 1
- `tcon_tmr_in`  in  4  TCON[7:4] (TR/TF bits) from timer block, merged on reads
- `int_ack_n`  in  1  vector acknowledge from interrupt controller, active low
- `int_so_num`  in  8  vector number presented with acknowledge
- `ext_int0_n`  in  1  INT0# pin, async, active low
- `ext_int1_n`  in  1  INT1# pin, async, active low
- `int_exIO0`  out  1  IE0 flag
- `int_exIO1`  out  1  IE1 flag

## Operation
- Registers: IT0=TCON[0], IE0=TCON[1], IT1=TCON[2], IE1=TCON[3]. All reset to 0.
- Channel x (0/1): `SYNC_STAGES` flops sample `ext_intx_n`. Sync flops and the previous-sample flop reset to 1 (inactive), so no edge is seen after reset.
- Edge mode (ITx=1): a falling edge (prev=1, cur=0) sets IEx. IEx stays set until cleared by acknowledge or a software write of 0.
- Level mode (ITx=0): IEx is written each cycle with the inverted synchronised pin. Software writes to the IEx bit are ignored.
- Acknowledge clear: when `int_ack_n`=0, ITx=1 and `int_so_num`==`INT_VECTOR_0` (x=0) or `INT_VECTOR_2` (x=1), IEx clears. The clear is idempotent while ack is held low.
- Edge-mode priority per cycle: hardware edge set > software write > acknowledge clear.
- SFR write: `~mem_we_n & ~mem_sfr_n & mem_sel & mem_addr[7:0]==`TCON`` loads `mem_wdata[3:0]` into IT1/IE1/IT0/IE0. IEx is loaded only when ITx=1 (the pre-write value). Bits [7:4] are ignored.
- SFR read: under the same decode with `~mem_rd_n`, `mem_rdata` = {`tcon_tmr_in`, IE1, IT1, IE0, IT0}. Otherwise `mem_rdata` = 8'hzz. Read is combinational.
- `int_exIOx` = IEx, driven directly from the flop.

## Timing
- Reset: `int_exIO0`=`int_exIO1`=0, `mem_rdata`=z, `mem_ready_out`=1, all flags/modes 0.
- Pin-to-flag latency: a pin falling before edge N sets IEx visibly after edge N+`SYNC_STAGES` (filter off). Level mode has the same latency for assert and deassert.
- Edge pulse minimum: the pin must be low for at least 1 sampled cycle, and high for at least 1 sampled cycle before it, to register.
- SFR write takes effect at the next edge. A read issued in the cycle after a write returns the new value.
- Mode switch 1→0: IEx tracks the level starting the cycle after the IT write. Switch 0→1: a pin already low does not set IEx until it goes high and then low again.
- Reset asserted mid-operation: all state returns to reset values at that edge. Pending edges are lost.

## Configuration
- `EXINT_GLITCH_FILTER_EN` defined: after synchronisation, a per-channel counter requires `FILTER_LEN` consecutive equal samples before the filtered level changes. Latency grows by `FILTER_LEN` cycles. Pulses shorter than `FILTER_LEN` cycles are discarded. The filtered level resets to 1.
- Not defined: no filter. The synchronised sample feeds edge/level logic directly.

## Test plan
- Reset, then IT0=1 via TCON write 8'h01; drive INT0# low 1 cycle → `int_exIO0`=1 after 2 cycles; TCON read = {tcon_tmr_in,4'b0011}.
- Hold `int_ack_n`=0 with `int_so_num`=`INT_VECTOR_0` for 3 cycles → IE0 clears next edge and stays 0; IE1 is unaffected.
- Level mode: INT1# low for 10 cycles → `int_exIO1` high for 10 cycles delayed by 2; software write 8'h08 while pin high → IE1 remains 0.
- Same cycle: INT0# edge reaches detector, TCON write 8'h01 (IE0=0), and ack for vector 0 → IE0=1.
- Mode switch: INT0# held low, write TCON 8'h01 → IE0 stays 0 until pin goes high then low again.
- With `EXINT_GLITCH_FILTER_EN`, `FILTER_LEN`=3: 2-cycle low pulse → no flag; 3-cycle low pulse → IE0 set 5 cycles after the pin falls.

Source files
------------

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - INT0#/INT1# synchroniser, level/falling-edge detect and TCON[3:0] (IT0/IE0/IT1/IE1).
// Optional post-sync glitch filter enabled by defining EXINT_GLITCH_FILTER_EN.
module ext_int_ctrl #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          FILTER_LEN   = 3,
    parameter logic [7:0]  TCON         = 8'h88,
    parameter logic [7:0]  INT_VECTOR_0 = 8'h03,
    parameter logic [7:0]  INT_VECTOR_2 = 8'h13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_sel,
    input  logic [15:0] mem_addr,
    input  logic        mem_we_n,
    input  logic        mem_rd_n,
    input  logic        mem_sfr_n,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_ready_out,
    input  logic [3:0]  tcon_tmr_in,
    input  logic        int_ack_n,
    input  logic [7:0]  int_so_num,
    input  logic        ext_int0_n,
    input  logic        ext_int1_n,
    output logic        int_exIO0,
    output logic        int_exIO1
);

    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [1:0] pins;
    logic [1:0] level;
    logic [1:0] prev_q;
    logic [1:0] it_q;
    logic [1:0] ie_q;
    logic [1:0] ie_d;
    logic [1:0] fall;
    logic [1:0] ack_hit;
    logic [1:0] wr_ie;
    logic [1:0] wr_it;
    logic       sfr_hit;
    logic       sfr_wr;
    logic       sfr_rd;
    logic       unused_bits;

    assign pins = {ext_int1_n, ext_int0_n};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sync_q[i] <= '1;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
            end
        end
    end

`ifdef EXINT_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    filt_q;
    logic [CW-1:0] cnt_q [2];

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                filt_q[i] <= 1'b1;
                cnt_q[i]  <= '0;
            end else if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i][SYNC_STAGES-1];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_q[i] <= '0;
            end
        end
    end

    assign level = filt_q;
`else
    assign level = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
`endif

    assign sfr_hit = mem_sel & ~mem_sfr_n & (mem_addr[7:0] == TCON);
    assign sfr_wr  = sfr_hit & ~mem_we_n;
    assign sfr_rd  = sfr_hit & ~mem_rd_n;
    assign wr_ie   = {mem_wdata[3], mem_wdata[1]};
    assign wr_it   = {mem_wdata[2], mem_wdata[0]};
    assign fall    = prev_q & ~level;
    assign ack_hit = {~int_ack_n & (int_so_num == INT_VECTOR_2),
                      ~int_ack_n & (int_so_num == INT_VECTOR_0)};
    assign unused_bits = ^{mem_addr[15:8], mem_wdata[7:4]};

    // Edge mode: hardware edge beats a software write, which beats an acknowledge.
    always_comb begin
        ie_d = ie_q;
        for (int i = 0; i < 2; i++) begin
            if (!it_q[i]) begin
                ie_d[i] = ~level[i];
            end else if (fall[i]) begin
                ie_d[i] = 1'b1;
            end else if (sfr_wr) begin
                ie_d[i] = wr_ie[i];
            end else if (ack_hit[i]) begin
                ie_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 2'b11;
            it_q   <= 2'b00;
            ie_q   <= 2'b00;
        end else begin
            prev_q <= level;
            ie_q   <= ie_d;
            if (sfr_wr) begin
                it_q <= wr_it;
            end
        end
    end

    assign mem_rdata     = sfr_rd ? {tcon_tmr_in, ie_q[1], it_q[1], ie_q[0], it_q[0]} : 8'hzz;
    assign mem_ready_out = 1'b1;
    assign int_exIO0     = ie_q[0];
    assign int_exIO1     = ie_q[1];

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb/tb_ext_int_ctrl.sv - scoreboard bench for ext_int_ctrl; directed vectors, cycle-tagged expectations.
module tb_ext_int_ctrl;

`ifdef EXINT_GLITCH_FILTER_EN
    localparam int LAT = 5;
    localparam int PW  = 3;
`else
    localparam int LAT = 2;
    localparam int PW  = 1;
`endif

    logic        clk;
    logic        reset;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic        mem_we_n;
    logic        mem_rd_n;
    logic        mem_sfr_n;
    logic [7:0]  mem_wdata;
    wire  [7:0]  mem_rdata;
    logic        mem_ready_out;
    logic [3:0]  tcon_tmr_in;
    logic        int_ack_n;
    logic [7:0]  int_so_num;
    logic        ext_int0_n;
    logic        ext_int1_n;
    logic        int_exIO0;
    logic        int_exIO1;

    ext_int_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .mem_sel       (mem_sel),
        .mem_addr      (mem_addr),
        .mem_we_n      (mem_we_n),
        .mem_rd_n      (mem_rd_n),
        .mem_sfr_n     (mem_sfr_n),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready_out (mem_ready_out),
        .tcon_tmr_in   (tcon_tmr_in),
        .int_ack_n     (int_ack_n),
        .int_so_num    (int_so_num),
        .ext_int0_n    (ext_int0_n),
        .ext_int1_n    (ext_int1_n),
        .int_exIO0     (int_exIO0),
        .int_exIO1     (int_exIO1)
    );

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged with the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [7:0] act;
                case (sb[i].kind)
                    0:       act = {7'd0, int_exIO0};
                    1:       act = {7'd0, int_exIO1};
                    2:       act = mem_rdata;
                    default: act = {7'd0, mem_ready_out};
                endcase
                n_check++;
                if (sb[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: missed check at cycle %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
                end else if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h at cycle %0d", sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int at, input int kind, input logic [7:0] e, input string n);
        exp_t x;
        x.cyc  = at;
        x.kind = kind;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    task automatic idle_bus();
        mem_sel   = 1'b0;
        mem_sfr_n = 1'b1;
        mem_we_n  = 1'b1;
        mem_rd_n  = 1'b1;
    endtask

    task automatic wr_tcon(input logic [7:0] d);
        mem_sel   = 1'b1;
        mem_sfr_n = 1'b0;
        mem_we_n  = 1'b0;
        mem_addr  = 16'hFF88;
        mem_wdata = d;
        tick();
        idle_bus();
    endtask

    task automatic rd_tcon(input logic [7:0] e, input string n);
        mem_sel   = 1'b1;
        mem_sfr_n = 1'b0;
        mem_rd_n  = 1'b0;
        mem_addr  = 16'hFF88;
        push(cyc, 2, e, n);
        tick();
        idle_bus();
    endtask

    initial begin
        int t;
        int t2;
        reset       = 1'b1;
        idle_bus();
        mem_addr    = 16'h0000;
        mem_wdata   = 8'h00;
        tcon_tmr_in = 4'hA;
        int_ack_n   = 1'b1;
        int_so_num  = 8'h00;
        ext_int0_n  = 1'b1;
        ext_int1_n  = 1'b1;
        repeat (3) tick();
        push(cyc, 0, 8'h00, "rst_ie0");
        push(cyc, 1, 8'h00, "rst_ie1");
        push(cyc, 3, 8'h01, "rst_ready");
        reset = 1'b0;
        tick();
        rd_tcon(8'hA0, "rst_tcon");

        // Edge mode on channel 0, single-cycle pulse.
        wr_tcon(8'h01);
        rd_tcon(8'hA1, "tcon_it0");
        t = cyc;
        ext_int0_n = 1'b0;
        push(t + LAT, 0, 8'h00, "ie0_early");
        push(t + 1 + LAT, 0, 8'h01, "ie0_edge");
        repeat (PW) tick();
        ext_int0_n = 1'b1;
        wait_until(t + 1 + LAT);
        rd_tcon(8'hA3, "tcon_ie0");

        // Both channels in edge mode; IE0 kept by writing 1.
        wr_tcon(8'h07);
        rd_tcon(8'hA7, "tcon_07");
        t = cyc;
        ext_int1_n = 1'b0;
        push(t + 1 + LAT, 1, 8'h01, "ie1_edge");
        repeat (PW) tick();
        ext_int1_n = 1'b1;
        wait_until(t + 1 + LAT);
        rd_tcon(8'hAF, "tcon_both");

        // Acknowledge vector 0 held 3 cycles, then vector 2.
        t = cyc;
        int_ack_n  = 1'b0;
        int_so_num = 8'h03;
        push(t + 1, 0, 8'h00, "ack0_clr");
        push(t + 3, 0, 8'h00, "ack0_hold");
        push(t + 3, 1, 8'h01, "ack0_ie1_kept");
        repeat (3) tick();
        t = cyc;
        int_so_num = 8'h13;
        push(t + 1, 1, 8'h00, "ack2_clr");
        tick();
        int_ack_n  = 1'b1;
        int_so_num = 8'h00;

        // Level mode on channel 1, 10-cycle low.
        wr_tcon(8'h01);
        t = cyc;
        ext_int1_n = 1'b0;
        for (int k = LAT; k <= LAT + 11; k++) begin
            push(t + k, 1, (k >= LAT + 1 && k <= LAT + 10) ? 8'h01 : 8'h00, "lvl_ie1");
        end
        repeat (10) tick();
        ext_int1_n = 1'b1;
        wait_until(t + LAT + 12);
        wr_tcon(8'h08);
        t = cyc;
        push(t + 1, 1, 8'h00, "sw_ie1_ignored");
        rd_tcon(8'hA0, "tcon_lvl");

        // Edge, software write of 0 and ack all land on one edge: edge wins.
        wr_tcon(8'h01);
        t = cyc;
        ext_int0_n = 1'b0;
        repeat (PW) tick();
        ext_int0_n = 1'b1;
        wait_until(t + LAT);
        mem_sel    = 1'b1;
        mem_sfr_n  = 1'b0;
        mem_we_n   = 1'b0;
        mem_addr   = 16'hFF88;
        mem_wdata  = 8'h01;
        int_ack_n  = 1'b0;
        int_so_num = 8'h03;
        push(t + 1 + LAT, 0, 8'h01, "prio_edge");
        push(t + 2 + LAT, 0, 8'h01, "prio_hold");
        tick();
        idle_bus();
        int_ack_n  = 1'b1;
        int_so_num = 8'h00;
        repeat (LAT + 2) tick();

        // Mode switch 0->1 with pin already low: no flag until a fresh fall.
        wr_tcon(8'h00);
        repeat (LAT + 2) tick();
        t = cyc;
        ext_int0_n = 1'b0;
        push(t + 1 + LAT, 0, 8'h01, "lvl_ie0");
        wait_until(t + 1 + LAT);
        wr_tcon(8'h01);
        wr_tcon(8'h01);
        t = cyc;
        for (int k = 0; k < 5; k++) push(t + k, 0, 8'h00, "held_no_edge");
        repeat (4) tick();
        ext_int0_n = 1'b1;
        repeat (PW) tick();
        ext_int0_n = 1'b0;
        t2 = cyc;
        push(t2 + LAT, 0, 8'h00, "reedge_early");
        push(t2 + 1 + LAT, 0, 8'h01, "reedge");
        wait_until(t2 + 2 + LAT);

        // Reset mid-operation.
        reset = 1'b1;
        tick();
        push(cyc, 0, 8'h00, "midrst_ie0");
        reset = 1'b0;
        rd_tcon(8'hA0, "midrst_tcon");
        ext_int0_n = 1'b1;
        repeat (LAT + 4) tick();

`ifdef EXINT_GLITCH_FILTER_EN
        wr_tcon(8'h01);
        wr_tcon(8'h01);
        t = cyc;
        ext_int0_n = 1'b0;
        repeat (2) tick();
        ext_int0_n = 1'b1;
        for (int k = 1; k <= 8; k++) push(t + k, 0, 8'h00, "filt_short");
        repeat (8) tick();
        t = cyc;
        ext_int0_n = 1'b0;
        push(t + 5, 0, 8'h00, "filt_early");
        push(t + 6, 0, 8'h01, "filt_ie0");
        repeat (3) tick();
        ext_int0_n = 1'b1;
        repeat (6) tick();
`endif

        repeat (3) tick();
        foreach (sb[i]) begin
            n_check++;
            n_fail++;
            $display("FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
